game_controller: RTL
====================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter RESULT_CYCLES, default 100_000_000: number of cycles DISPLAY_RESULT_Jx and WIN are held (1 s at 100 MHz).
REQ-002 Parameter WINS_TO_END, default 4: round wins one player needs to reach FIM.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces reset values immediately.
REQ-005 enter  input  1  one-cycle, debounced confirm pulse from the push-button.
REQ-006 digits  input  16  four BCD digits, [15:12] = most significant.
REQ-007 current_state  output  state_t  registered game state, drives display_manager.
REQ-008 bulls  output  4  registered bull count of last guess, 0..4.
REQ-009 cows  output  4  registered cow count of last guess, 0..4.
REQ-010 win_flag  output  1  high while in WIN or FIM.
REQ-011 winner  output  1  0 = J1, 1 = J2; player who won last round.
REQ-012 wins_j1, wins_j2  output  3 each  round-win counters.
REQ-013 reject  output  1  one-cycle pulse when an enter is refused.

Function
REQ-014 The controller SHALL implement state sequence SECRET_J1 -> SECRET_J2 -> GUESS_J1 -> DISPLAY_RESULT_J1 -> GUESS_J2 -> DISPLAY_RESULT_J2 -> GUESS_J1 ...
REQ-015 In SECRET_Jx an accepted enter SHALL latch digits into secret_jx and advance on the same edge.
REQ-016 In GUESS_J1 an accepted enter SHALL compare digits against secret_j2 (GUESS_J2 against secret_j1), register bulls/cows on that edge, and enter DISPLAY_RESULT_Jx.
REQ-017 Bulls SHALL count positions with equal digits; cows SHALL count digits of the guess present in the secret at a different position, each secret digit matched at most once.
REQ-018 DISPLAY_RESULT_Jx SHALL last exactly RESULT_CYCLES cycles, then go to WIN if bulls == 4, else to the other player's GUESS state.
REQ-019 On entering WIN the guesser's counter SHALL increment and winner SHALL be set; counters saturate at 7.
REQ-020 WIN SHALL last RESULT_CYCLES cycles, then go to FIM if the winner's count equals WINS_TO_END, else to SECRET_J1 with bulls, cows and secrets cleared.
REQ-021 FIM SHALL be terminal; only reset leaves it.
REQ-022 enter SHALL be ignored (no reject pulse) in DISPLAY_RESULT_Jx, WIN and FIM.
REQ-023 The hold timer SHALL be $clog2(RESULT_CYCLES+1) bits, cleared on every state entry, with no wrap.
REQ-024 An enter arriving on the same edge the timer expires SHALL be ignored.

Reset
REQ-025 Reset SHALL give current_state = SECRET_J1, bulls = cows = 0, win_flag = 0, winner = 0, wins_j1 = wins_j2 = 0, reject = 0, secrets = 0, timer = 0.
REQ-026 Reset asserted mid-game, including during a hold, SHALL abort immediately with no partial counter update.

Configuration
REQ-027 With DIGIT_CHECK_EN defined, an enter in SECRET/GUESS states with any digit > 9 or any repeated digit SHALL be refused: state and data unchanged, reject pulses one cycle.
REQ-028 Without DIGIT_CHECK_EN all values SHALL be accepted, and reject SHALL be tied to 0.

Structure
REQ-029 Package game_pkg SHALL hold state_t (3-bit enum: SECRET_J1 = 0, SECRET_J2, GUESS_J1, GUESS_J2, DISPLAY_RESULT_J1, DISPLAY_RESULT_J2, WIN, FIM = 7), the blank-glyph constant and the default WINS_TO_END.
REQ-030 Sub-module bulls_cows_compare (combinational, guess + secret -> bulls, cows) SHALL be instantiated once, with its secret input muxed by state.

Verification
REQ-031 Secrets 1234/5678; J1 guesses 5687 -> DISPLAY_RESULT_J1, bulls = 2, cows = 2; after RESULT_CYCLES -> GUESS_J2.
REQ-032 J2 guesses 1234 -> bulls = 4 -> WIN, wins_j2 = 1, winner = 1, win_flag = 1; after hold -> SECRET_J1, bulls = cows = 0.
REQ-033 J2 wins four rounds -> FIM; subsequent enters change nothing; reset -> SECRET_J1 with all counters 0.
REQ-034 DIGIT_CHECK_EN: secret 1123 or 12A4 -> reject pulse, state stays SECRET_J1; without macro, 1123 is accepted.
REQ-035 Reset asserted in the middle of DISPLAY_RESULT_J1 -> immediate SECRET_J1, wins unchanged at 0.
REQ-036 Enter during DISPLAY_RESULT_J2 and on the timer-expiry edge -> ignored; next state is decided by bulls only.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the two-player bulls-and-cows game controller.
package game_pkg;

    typedef enum logic [2:0] {
        SECRET_J1         = 3'd0,
        SECRET_J2         = 3'd1,
        GUESS_J1          = 3'd2,
        GUESS_J2          = 3'd3,
        DISPLAY_RESULT_J1 = 3'd4,
        DISPLAY_RESULT_J2 = 3'd5,
        WIN               = 3'd6,
        FIM               = 3'd7
    } state_t;

    localparam logic [3:0] BLANK_GLYPH         = 4'hF;
    localparam int         WINS_TO_END_DEFAULT = 4;

    // A code is usable only if every nibble is a decimal digit and no digit repeats.
    function automatic logic digitsValid(input logic [15:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (code[4*i +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < 4; j++) begin
                if (code[4*i +: 4] == code[4*j +: 4]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic [2:0] satInc3(input logic [2:0] count);
        return (count == 3'd7) ? count : count + 3'd1;
    endfunction

endpackage

// File: rtl/bulls_cows_compare.sv
// Combinational scorer: bulls are exact position matches, cows are remaining
// guess digits found elsewhere in the secret, each secret digit used once.
module bulls_cows_compare
    import game_pkg::*;
(
    input  logic [15:0] guess_i,
    input  logic [15:0] secret_i,
    output logic [3:0]  bulls_o,
    output logic [3:0]  cows_o
);

    logic [3:0] isBull;
    logic [3:0] secretUsed;
    logic       matched;

    // Bull positions consume their secret digit before any cow search starts.
    always_comb begin
        bulls_o    = 4'd0;
        cows_o     = 4'd0;
        isBull     = 4'b0;
        secretUsed = 4'b0;
        matched    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (guess_i[4*i +: 4] == secret_i[4*i +: 4]) begin
                isBull[i]     = 1'b1;
                secretUsed[i] = 1'b1;
                bulls_o       = bulls_o + 4'd1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            matched = 1'b0;
            if (!isBull[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!matched && !secretUsed[j] &&
                        (secret_i[4*j +: 4] == guess_i[4*i +: 4])) begin
                        secretUsed[j] = 1'b1;
                        matched       = 1'b1;
                        cows_o        = cows_o + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/game_controller.sv
// Round/turn sequencer for two-player bulls-and-cows with timed result holds.
// Optional DIGIT_CHECK_EN refuses codes with non-decimal or repeated digits.
module game_controller
    import game_pkg::*;
#(
    parameter int RESULT_CYCLES = 100_000_000,
    parameter int WINS_TO_END   = WINS_TO_END_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enter,
    input  logic [15:0] digits,
    output state_t      current_state,
    output logic [3:0]  bulls,
    output logic [3:0]  cows,
    output logic        win_flag,
    output logic        winner,
    output logic [2:0]  wins_j1,
    output logic [2:0]  wins_j2,
    output logic        reject
);

    localparam int            TW         = $clog2(RESULT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(RESULT_CYCLES - 1);

    state_t        state_q;
    logic [15:0]   secretJ1_q;
    logic [15:0]   secretJ2_q;
    logic [3:0]    bulls_q;
    logic [3:0]    cows_q;
    logic          winFlag_q;
    logic          winner_q;
    logic [2:0]    winsJ1_q;
    logic [2:0]    winsJ2_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    logic          timerDone;
    logic          digitsOk;
    logic          entryState;
    logic          acceptEnter;
    logic [15:0]   secretSel;
    logic [3:0]    cmpBulls;
    logic [3:0]    cmpCows;
    logic [2:0]    winnerCount;

    // J1 guesses against J2's secret and vice versa; one shared scorer.
    assign secretSel = (state_q == GUESS_J1) ? secretJ2_q : secretJ1_q;

    bulls_cows_compare uCompare (
        .guess_i  (digits),
        .secret_i (secretSel),
        .bulls_o  (cmpBulls),
        .cows_o   (cmpCows)
    );

    always_comb begin
        timerDone   = (timer_q == TIMER_LAST);
        timer_d     = timerDone ? timer_q : timer_q + 1'b1;
        entryState  = state_q inside {SECRET_J1, SECRET_J2, GUESS_J1, GUESS_J2};
        acceptEnter = enter && entryState && digitsOk;
        winnerCount = winner_q ? winsJ2_q : winsJ1_q;
    end

`ifdef DIGIT_CHECK_EN
    logic reject_q;

    assign digitsOk = digitsValid(digits);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) reject_q <= 1'b0;
        else       reject_q <= enter && entryState && !digitsOk;
    end

    assign reject = reject_q;
`else
    assign digitsOk = 1'b1;
    assign reject   = 1'b0;
`endif

    // Hold states run the timer from zero; every exit returns it to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= SECRET_J1;
            secretJ1_q <= 16'h0;
            secretJ2_q <= 16'h0;
            bulls_q    <= 4'd0;
            cows_q     <= 4'd0;
            winFlag_q  <= 1'b0;
            winner_q   <= 1'b0;
            winsJ1_q   <= 3'd0;
            winsJ2_q   <= 3'd0;
            timer_q    <= '0;
        end else begin
            case (state_q)
                SECRET_J1: if (acceptEnter) begin
                    secretJ1_q <= digits;
                    state_q    <= SECRET_J2;
                end
                SECRET_J2: if (acceptEnter) begin
                    secretJ2_q <= digits;
                    state_q    <= GUESS_J1;
                end
                GUESS_J1: if (acceptEnter) begin
                    bulls_q <= cmpBulls;
                    cows_q  <= cmpCows;
                    state_q <= DISPLAY_RESULT_J1;
                end
                GUESS_J2: if (acceptEnter) begin
                    bulls_q <= cmpBulls;
                    cows_q  <= cmpCows;
                    state_q <= DISPLAY_RESULT_J2;
                end
                DISPLAY_RESULT_J1: begin
                    if (timerDone) begin
                        timer_q <= '0;
                        if (bulls_q == 4'd4) begin
                            state_q   <= WIN;
                            winsJ1_q  <= satInc3(winsJ1_q);
                            winner_q  <= 1'b0;
                            winFlag_q <= 1'b1;
                        end else begin
                            state_q <= GUESS_J2;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                DISPLAY_RESULT_J2: begin
                    if (timerDone) begin
                        timer_q <= '0;
                        if (bulls_q == 4'd4) begin
                            state_q   <= WIN;
                            winsJ2_q  <= satInc3(winsJ2_q);
                            winner_q  <= 1'b1;
                            winFlag_q <= 1'b1;
                        end else begin
                            state_q <= GUESS_J1;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                WIN: begin
                    if (timerDone) begin
                        timer_q <= '0;
                        if (int'(winnerCount) == WINS_TO_END) begin
                            state_q <= FIM;
                        end else begin
                            state_q    <= SECRET_J1;
                            bulls_q    <= 4'd0;
                            cows_q     <= 4'd0;
                            secretJ1_q <= 16'h0;
                            secretJ2_q <= 16'h0;
                            winFlag_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                FIM: ;
                default: state_q <= SECRET_J1;
            endcase
        end
    end

    assign current_state = state_q;
    assign bulls         = bulls_q;
    assign cows          = cows_q;
    assign win_flag      = winFlag_q;
    assign winner        = winner_q;
    assign wins_j1       = winsJ1_q;
    assign wins_j2       = winsJ2_q;

endmodule
